// File: rtl/time_set_pkg.sv
// Time-set front-end shared types, field codes and BCD helpers.
// Used by time_set_ctrl and btn_debounce.
package time_set_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HR,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } state_t;

    localparam logic [1:0] FS_NONE = 2'd0;
    localparam logic [1:0] FS_HR   = 2'd1;
    localparam logic [1:0] FS_MIN  = 2'd2;
    localparam logic [1:0] FS_SEC  = 2'd3;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    // One BCD step with wrap at max; corrupt digits or values past max clamp to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max);
        logic [7:0] r;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'h0};
        else
            r = v + 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low key -> 2-flop synchroniser -> stability counter.
// Emits the debounced level and a one-cycle press pulse on its 1->0 edge.
import time_set_pkg::*;

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous key into the clock domain; idle level is released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Adopt the synced level after it has differed long enough; any bounce restarts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (s2 != level) begin
                if (cnt == LAST) begin
                    cnt   <= '0;
                    level <= s2;
                    press <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-set front-end: key debounce, hr/min/sec edit FSM, blink and load pulse.
// Optional key auto-repeat is built when TIME_SET_AUTOREPEAT_EN is defined.
import time_set_pkg::*;

module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int BLINK_HALF_CYCLES = 12500000,
    parameter int REPEAT_DELAY      = 25000000,
    parameter int REPEAT_RATE       = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] cur_time_bcd,
    output logic [23:0] set_time_bcd,
    output logic        load,
    output logic        editing,
    output logic [1:0]  field_sel,
    output logic [2:0]  blank_mask
);

    localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

    state_t        state;
    logic          mode_press;
    logic          inc_press;
    logic          mode_level_unused;
    logic          inc_level;
    logic          rpt_pulse;
    logic          inc_evt;
    logic          restart;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .level (mode_level_unused),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                          : REPEAT_RATE;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_armed;

    // Held key in an edit field: first repeat after the delay, then at the rate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            rpt_pulse <= 1'b0;
        end else begin
            rpt_pulse <= 1'b0;
            if (!editing || inc_level || mode_press || inc_press) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b0;
            end else if (rpt_cnt == (rpt_armed ? RATE_LAST : DLY_LAST)) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b1;
                rpt_pulse <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    // Auto-repeat not built: the repeat path is tied off.
    assign rpt_pulse = inc_level & (REPEAT_DELAY < 0) & (REPEAT_RATE < 0);
`endif

    assign inc_evt = inc_press | rpt_pulse;
    assign restart = mode_press | (state == COMMIT) | (editing & inc_evt);

    // Edit FSM with registered outputs; mode has priority over increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            set_time_bcd <= '0;
            load         <= 1'b0;
            editing      <= 1'b0;
            field_sel    <= FS_NONE;
        end else begin
            load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mode_press) begin
                        state        <= EDIT_HR;
                        set_time_bcd <= cur_time_bcd;
                        editing      <= 1'b1;
                        field_sel    <= FS_HR;
                    end
                end
                EDIT_HR: begin
                    if (mode_press) begin
                        state     <= EDIT_MIN;
                        field_sel <= FS_MIN;
                    end else if (inc_evt) begin
                        set_time_bcd[23:16] <= bcd_inc(set_time_bcd[23:16], HR_MAX);
                    end
                end
                EDIT_MIN: begin
                    if (mode_press) begin
                        state     <= EDIT_SEC;
                        field_sel <= FS_SEC;
                    end else if (inc_evt) begin
                        set_time_bcd[15:8] <= bcd_inc(set_time_bcd[15:8], MS_MAX);
                    end
                end
                EDIT_SEC: begin
                    if (mode_press) begin
                        state     <= COMMIT;
                        load      <= 1'b1;
                        editing   <= 1'b0;
                        field_sel <= FS_NONE;
                    end else if (inc_evt) begin
                        set_time_bcd[7:0] <= bcd_inc(set_time_bcd[7:0], MS_MAX);
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    editing   <= 1'b0;
                    field_sel <= FS_NONE;
                end
            endcase
        end
    end

    // Blink phase for the edited field; restarts visible on any state change or increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (restart || !editing) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Map the blank phase onto the selected digit pair.
    always_comb begin
        blank_mask = 3'b000;
        if (blink_phase) begin
            unique case (1'b1)
                (field_sel == FS_HR):  blank_mask = 3'b100;
                (field_sel == FS_MIN): blank_mask = 3'b010;
                (field_sel == FS_SEC): blank_mask = 3'b001;
                default:               blank_mask = 3'b000;
            endcase
        end
    end

endmodule
